// File: rtl/uoram_recursion_sched_if.sv
// rtl/uoram_recursion_sched_if.sv - client request, PLB lookup and backend command bundle
interface uoram_recursion_sched_if #(
  parameter int ORAMU       = 32,
  parameter int NumChannels = 2,
  parameter int BECMDWidth  = 2,
  parameter int ErrCntWidth = 8,
  parameter int ChanW       = (NumChannels > 1) ? $clog2(NumChannels) : 1
);
  logic [NumChannels-1:0]            CmdInValid;
  logic [NumChannels-1:0]            CmdInReady;
  logic [NumChannels*BECMDWidth-1:0] CmdIn;
  logic [NumChannels*ORAMU-1:0]      AddrIn;
  logic                              LkupValid;
  logic                              LkupReady;
  logic [ORAMU-1:0]                  LkupAddr;
  logic                              RespValid;
  logic                              RespHit;
  logic                              RespUnInit;
  logic                              InitPulse;
  logic                              CmdOutValid;
  logic                              CmdOutReady;
  logic [BECMDWidth-1:0]             CmdOut;
  logic [ORAMU-1:0]                  AddrOut;
  logic [ChanW-1:0]                  ChanOut;
  logic                              Busy;
  logic [ErrCntWidth-1:0]            ErrCount;
  logic [ORAMU-1:0]                  ErrAddr;

  // slave is the scheduler; master is the clients, PLB and backend
  modport slave (
    input  CmdInValid, CmdIn, AddrIn, LkupReady, RespValid, RespHit, RespUnInit, CmdOutReady,
    output CmdInReady, LkupValid, LkupAddr, InitPulse, CmdOutValid, CmdOut, AddrOut,
           ChanOut, Busy, ErrCount, ErrAddr
  );
  modport master (
    output CmdInValid, CmdIn, AddrIn, LkupReady, RespValid, RespHit, RespUnInit, CmdOutReady,
    input  CmdInReady, LkupValid, LkupAddr, InitPulse, CmdOutValid, CmdOut, AddrOut,
           ChanOut, Busy, ErrCount, ErrAddr
  );
endinterface

// File: rtl/uoram_recursion_sched.sv
// rtl/uoram_recursion_sched.sv - multi-channel recursive PosMap walk and backend command scheduler
module uoram_recursion_sched #(
  parameter int ORAMU         = 32,
  parameter int Recursion     = 3,
  parameter int LeafInBlock   = 16,
  parameter int NumValidBlock = 1024,
  parameter int NumChannels   = 2,
  parameter int BECMDWidth    = 2,
  parameter int CmdReadRmv    = 2,
  parameter int CmdAppend     = 3,
  parameter int EnablePLB     = 1,
  parameter int ErrCntWidth   = 8
) (
  input logic Clock,
  input logic Reset,
  uoram_recursion_sched_if.slave Bus
);
  localparam int ChanW  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int DepthW = (Recursion > 1) ? $clog2(Recursion) : 1;
  localparam int ShiftW = $clog2(LeafInBlock);
  localparam logic [ORAMU-1:0]  NumValidL = ORAMU'(NumValidBlock);
  localparam logic [DepthW-1:0] TopDepth  = DepthW'(Recursion - 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT, ACCESS, INIT} state_t;
  state_t state, nextState;

  logic [ORAMU-1:0]       addrQ [Recursion];
  logic [DepthW-1:0]      qDepth;
  logic [Recursion-1:0]   unInit;
  logic [BECMDWidth-1:0]  cmdLatch;
  logic [ChanW-1:0]       rrPtr, chanReg, grant;
  logic                   grantValid;
  logic [ErrCntWidth-1:0] errCount;
  logic [ORAMU-1:0]       errAddr;

  logic [ORAMU-1:0]      curAddr, reqAddr, nextAddr;
  logic [BECMDWidth-1:0] reqCmd;
  logic                  reqInRange, lastLevel, miss, skipLevel;

  assign curAddr    = addrQ[qDepth];
  assign reqAddr    = Bus.AddrIn[int'(grant)*ORAMU +: ORAMU];
  assign reqCmd     = Bus.CmdIn[int'(grant)*BECMDWidth +: BECMDWidth];
  assign reqInRange = reqAddr < NumValidL;
  assign lastLevel  = (qDepth == TopDepth);
  assign nextAddr   = NumValidL + (curAddr >> ShiftW);
  assign miss       = (!Bus.RespHit || (EnablePLB == 0)) && !lastLevel;
  // an uninitialised PosMap level is refilled by the PLB instead of being read from the backend
  assign skipLevel  = (qDepth != '0) && unInit[qDepth];

  // nearest valid channel after the last grant wins; scanning farthest-first lets the nearest overwrite
  always_comb begin
    grant      = rrPtr;
    grantValid = 1'b0;
    for (int i = NumChannels; i >= 1; i--) begin
      int idx;
      idx = (int'(rrPtr) + i) % NumChannels;
      if (Bus.CmdInValid[idx]) begin
        grant      = ChanW'(idx);
        grantValid = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState       = state;
    Bus.CmdInReady  = '0;
    Bus.LkupValid   = 1'b0;
    Bus.LkupAddr    = '0;
    Bus.InitPulse   = 1'b0;
    Bus.CmdOutValid = 1'b0;
    Bus.CmdOut      = '0;
    Bus.AddrOut     = '0;
    case (state)
      IDLE: begin
        if (grantValid && Reset) begin
          Bus.CmdInReady[grant] = 1'b1;
          if (reqInRange) nextState = LOOKUP;
        end
      end
      LOOKUP: begin
        Bus.LkupValid = 1'b1;
        Bus.LkupAddr  = curAddr;
        if (Bus.LkupReady) nextState = WAIT;
      end
      WAIT: begin
        if (Bus.RespValid) nextState = miss ? LOOKUP : ACCESS;
      end
      ACCESS: begin
        if (skipLevel) begin
          nextState = INIT;
        end else begin
          Bus.CmdOutValid = 1'b1;
          Bus.AddrOut     = curAddr;
          if (qDepth != '0)   Bus.CmdOut = BECMDWidth'(CmdReadRmv);
          else if (unInit[0]) Bus.CmdOut = BECMDWidth'(CmdAppend);
          else                Bus.CmdOut = cmdLatch;
          if (Bus.CmdOutReady && qDepth == '0) nextState = IDLE;
        end
      end
      INIT: begin
        Bus.InitPulse = 1'b1;
        nextState     = ACCESS;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < Recursion; i++) addrQ[i] <= '0;
      qDepth   <= '0;
      unInit   <= '0;
      cmdLatch <= '0;
      rrPtr    <= '0;
      chanReg  <= '0;
      errCount <= '0;
      errAddr  <= '0;
    end else begin
      case (state)
        IDLE: if (grantValid) begin
          rrPtr <= grant;
          if (reqInRange) begin
            cmdLatch <= reqCmd;
            chanReg  <= grant;
            addrQ[0] <= reqAddr;
            qDepth   <= '0;
            unInit   <= '0;
          end else begin
            if (errCount != '1) errCount <= errCount + 1'b1;
            if (errCount == '0) errAddr  <= reqAddr;
          end
        end
        WAIT: if (Bus.RespValid) begin
          unInit[qDepth] <= Bus.RespUnInit;
          if (miss) begin
            addrQ[qDepth + 1'b1] <= nextAddr;
            qDepth               <= qDepth + 1'b1;
          end
        end
        ACCESS: if (!skipLevel && Bus.CmdOutReady && qDepth != '0) qDepth <= qDepth - 1'b1;
        INIT:   qDepth <= qDepth - 1'b1;
        default: ;
      endcase
    end
  end

  assign Bus.ChanOut  = chanReg;
  assign Bus.Busy     = (state != IDLE);
  assign Bus.ErrCount = errCount;
  assign Bus.ErrAddr  = errAddr;
endmodule

// File: tb/tb_uoram_recursion_sched.sv
// tb/tb_uoram_recursion_sched.sv - directed bench with a transaction-level model of the walk and access order
module tb_uoram_recursion_sched;
  localparam int R = 3;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic useB  = 1'b0;
  always #5 Clock = ~Clock;

  logic [1:0]  cmdInValid = '0;
  logic [3:0]  cmdIn      = '0;
  logic [63:0] addrIn     = '0;
  logic lkupReady = 1'b1, respValid = 1'b0, respHit = 1'b0, respUnInit = 1'b0, cmdOutReady = 1'b1;

  uoram_recursion_sched_if ifA ();
  uoram_recursion_sched_if ifB ();

  assign ifA.CmdInValid = cmdInValid;  assign ifB.CmdInValid = cmdInValid;
  assign ifA.CmdIn = cmdIn;            assign ifB.CmdIn = cmdIn;
  assign ifA.AddrIn = addrIn;          assign ifB.AddrIn = addrIn;
  assign ifA.LkupReady = lkupReady;    assign ifB.LkupReady = lkupReady;
  assign ifA.RespValid = respValid;    assign ifB.RespValid = respValid;
  assign ifA.RespHit = respHit;        assign ifB.RespHit = respHit;
  assign ifA.RespUnInit = respUnInit;  assign ifB.RespUnInit = respUnInit;
  assign ifA.CmdOutReady = cmdOutReady; assign ifB.CmdOutReady = cmdOutReady;

  uoram_recursion_sched #(.EnablePLB(1)) dutA (.Clock(Clock), .Reset(Reset), .Bus(ifA));
  uoram_recursion_sched #(.EnablePLB(0)) dutB (.Clock(Clock), .Reset(Reset), .Bus(ifB));

  wire [1:0]  oReady = useB ? ifB.CmdInReady  : ifA.CmdInReady;
  wire        oLkV   = useB ? ifB.LkupValid   : ifA.LkupValid;
  wire [31:0] oLkA   = useB ? ifB.LkupAddr    : ifA.LkupAddr;
  wire        oInit  = useB ? ifB.InitPulse   : ifA.InitPulse;
  wire        oCmdV  = useB ? ifB.CmdOutValid : ifA.CmdOutValid;
  wire [1:0]  oCmd   = useB ? ifB.CmdOut      : ifA.CmdOut;
  wire [31:0] oAddr  = useB ? ifB.AddrOut     : ifA.AddrOut;
  wire        oChan  = useB ? ifB.ChanOut     : ifA.ChanOut;
  wire        oBusy  = useB ? ifB.Busy        : ifA.Busy;
  wire [7:0]  oErrC  = useB ? ifB.ErrCount    : ifA.ErrCount;
  wire [31:0] oErrA  = useB ? ifB.ErrAddr     : ifA.ErrAddr;

  int checks = 0;
  int errors = 0;

  // model state
  logic        expIdle = 1'b1;
  int          rr = 0;
  logic [7:0]  mErrCnt = '0;
  logic [31:0] mErrAddr = '0;
  logic [31:0] expLk [$];
  logic [34:0] expEv [$];   // {isInit, cmd, addr}
  logic        expChan = 1'b0;
  logic        scrHit [R];
  logic        scrUn  [R];
  int          lkIdx = 0, holdIdx = -1, lkStall = 0, cmdStall = 0, acceptCnt = 0, initLog = 0;
  logic        respPending = 0, respActive = 0, pHit = 0, pUn = 0;
  logic        lkHold = 0, cmdHold = 0;
  logic [31:0] lkHoldAddr = '0;
  logic [33:0] cmdHoldWord = '0;
  logic [31:0] lkLog [$];
  logic [33:0] cmdLog [$];
  int          grantLog [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] arb(input logic [1:0] v, input int r);
    for (int i = 1; i <= 2; i++) begin
      int c;
      c = (r + i) % 2;
      if (v[c]) return 2'b01 << c;
    end
    return 2'b00;
  endfunction

  // expected lookups and backend events straight from the walk/access rules
  task automatic buildModel(input logic [1:0] c, input logic [31:0] a);
    logic [31:0] addrs [R];
    int d;
    addrs[0] = a;
    d = 0;
    while (d < R - 1 && (!scrHit[d] || useB)) begin
      addrs[d+1] = 32'd1024 + addrs[d] / 16;
      d++;
    end
    for (int k = 0; k <= d; k++) expLk.push_back(addrs[k]);
    for (int k = d; k >= 0; k--) begin
      if (k == 0)         expEv.push_back({1'b0, scrUn[0] ? 2'd3 : c, addrs[0]});
      else if (scrUn[k])  expEv.push_back({1'b1, 2'd0, addrs[k]});
      else                expEv.push_back({1'b0, 2'd2, addrs[k]});
    end
  endtask

  initial begin
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        chk("reset_outputs", {oReady, oLkV, oLkA, oInit, oCmdV, oCmd, oAddr, oChan, oBusy, oErrC, oErrA}, '0);
        expIdle = 1'b1; rr = 0; mErrCnt = '0; mErrAddr = '0;
        expLk.delete(); expEv.delete();
        respPending = 0; respActive = 0; respValid = 0; lkHold = 0; cmdHold = 0;
        lkupReady = 1; cmdOutReady = 1;
      end else begin
        logic [1:0] eReady;
        if (respActive) begin respValid = 0; respActive = 0; end
        if (respPending) begin
          respValid = 1; respHit = pHit; respUnInit = pUn; respPending = 0; respActive = 1;
        end
        lkupReady = !(oLkV && lkStall > 0);
        if (oLkV && lkStall > 0) lkStall--;
        cmdOutReady = !(oCmdV && cmdStall > 0);
        if (oCmdV && cmdStall > 0) cmdStall--;
        if (lkHold)  chk("lkup_stable", {oLkV, oLkA}, {1'b1, lkHoldAddr});
        if (cmdHold) chk("cmd_stable", {oCmdV, oCmd, oAddr}, {1'b1, cmdHoldWord});
        lkHold = oLkV && !lkupReady;  lkHoldAddr = oLkA;
        cmdHold = oCmdV && !cmdOutReady; cmdHoldWord = {oCmd, oAddr};

        chk("busy", oBusy, !expIdle);
        eReady = expIdle ? arb(cmdInValid, rr) : 2'b00;
        chk("in_ready", oReady, eReady);
        chk("err_count", oErrC, mErrCnt);
        chk("err_addr", oErrA, mErrAddr);

        if (oLkV) begin
          chk("lkup_expected", expLk.size() > 0, 1);
          if (expLk.size() > 0) chk("lkup_addr", oLkA, expLk[0]);
          if (lkupReady) begin
            lkLog.push_back(oLkA);
            if (expLk.size() > 0) void'(expLk.pop_front());
            if (lkIdx != holdIdx && lkIdx < R) begin
              respPending = 1; pHit = scrHit[lkIdx]; pUn = scrUn[lkIdx];
            end
            lkIdx++;
          end
        end
        if (oInit) begin
          chk("init_expected", expEv.size() > 0 && expEv[0][34], 1);
          initLog++;
          if (expEv.size() > 0 && expEv[0][34]) void'(expEv.pop_front());
        end
        if (oCmdV) begin
          logic has;
          has = expEv.size() > 0 && !expEv[0][34];
          chk("cmd_expected", has, 1);
          if (has) chk("cmd_out", {oCmd, oAddr}, expEv[0][33:0]);
          chk("chan_out", oChan, expChan);
          if (cmdOutReady) begin
            cmdLog.push_back({oCmd, oAddr});
            if (has) void'(expEv.pop_front());
            if (expEv.size() == 0) expIdle = 1'b1;
          end
        end
        if (eReady != 2'b00) begin
          int g;
          logic [31:0] a;
          g = eReady[1] ? 1 : 0;
          a = addrIn[g*32 +: 32];
          rr = g; grantLog.push_back(g); acceptCnt++;
          if (a >= 32'd1024) begin
            if (mErrCnt == 0) mErrAddr = a;
            if (mErrCnt != 8'hFF) mErrCnt++;
          end else begin
            buildModel(cmdIn[g*2 +: 2], a);
            expIdle = 1'b0; expChan = g[0]; lkIdx = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  task automatic doReset();
    Reset = 0; repeat (2) tick(); Reset = 1; tick();
  endtask

  task automatic setScript(input logic h0, h1, h2, u0, u1, u2);
    scrHit[0] = h0; scrHit[1] = h1; scrHit[2] = h2;
    scrUn[0] = u0;  scrUn[1] = u1;  scrUn[2] = u2;
  endtask

  task automatic clearLogs();
    lkLog.delete(); cmdLog.delete(); grantLog.delete(); initLog = 0;
  endtask

  task automatic request(input int ch, input logic [1:0] c, input logic [31:0] a);
    int base;
    base = acceptCnt;
    cmdIn[ch*2 +: 2] = c; addrIn[ch*32 +: 32] = a; cmdInValid[ch] = 1'b1;
    for (int n = 0; n < 100 && acceptCnt == base; n++) tick();
    chk("accept_timeout", acceptCnt > base, 1);
    cmdInValid[ch] = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (n < 300 && !(expIdle && expEv.size() == 0 && expLk.size() == 0)) begin tick(); n++; end
    chk("idle_timeout", n < 300, 1);
    tick();
  endtask

  task automatic chkLogs(input string n, input int nlk, input logic [31:0] lk [3],
                         input int ncm, input logic [33:0] cm [3], input int ni);
    chk({n, "_lookup_count"}, lkLog.size(), nlk);
    for (int i = 0; i < nlk && i < lkLog.size(); i++) chk({n, "_lookup"}, lkLog[i], lk[i]);
    chk({n, "_cmd_count"}, cmdLog.size(), ncm);
    for (int i = 0; i < ncm && i < cmdLog.size(); i++) chk({n, "_cmd"}, cmdLog[i], cm[i]);
    chk({n, "_init_count"}, initLog, ni);
  endtask

  initial begin
    setScript(1, 1, 1, 0, 0, 0);
    doReset();

    // hit at depth 0
    clearLogs(); setScript(1, 1, 1, 0, 0, 0);
    request(0, 2'd0, 32'd100); waitIdle();
    chkLogs("hit0", 1, '{32'd100, 32'd0, 32'd0}, 1, '{{2'd0, 32'd100}, 34'd0, 34'd0}, 0);

    // misses at depths 0 and 1, with a stalled lookup
    clearLogs(); setScript(0, 0, 0, 0, 0, 0); lkStall = 3;
    request(0, 2'd0, 32'd100); waitIdle();
    chkLogs("miss_chain", 3, '{32'd100, 32'd1030, 32'd1088},
            3, '{{2'd2, 32'd1088}, {2'd2, 32'd1030}, {2'd0, 32'd100}}, 0);

    // uninitialised levels on the walk back, backend stalled 5 cycles
    clearLogs(); setScript(0, 1, 1, 1, 1, 0); cmdStall = 5;
    request(0, 2'd0, 32'd100); waitIdle();
    chkLogs("uninit", 2, '{32'd100, 32'd1030, 32'd0}, 1, '{{2'd3, 32'd100}, 34'd0, 34'd0}, 1);

    // PLB disabled: hits ignored below the top level
    useB = 1; doReset();
    clearLogs(); setScript(1, 1, 1, 0, 0, 0);
    request(0, 2'd0, 32'd100); waitIdle();
    chkLogs("noplb", 3, '{32'd100, 32'd1030, 32'd1088},
            3, '{{2'd2, 32'd1088}, {2'd2, 32'd1030}, {2'd0, 32'd100}}, 0);
    useB = 0; doReset();

    // round robin with both channels continuously valid
    clearLogs(); setScript(1, 1, 1, 0, 0, 0);
    cmdIn = {2'd1, 2'd0}; addrIn = {32'd300, 32'd200}; cmdInValid = 2'b11;
    for (int n = 0; n < 200 && grantLog.size() < 4; n++) tick();
    cmdInValid = 2'b00;
    waitIdle();
    chk("rr_count", grantLog.size(), 4);
    if (grantLog.size() >= 4)
      chk("rr_order", {grantLog[0][1:0], grantLog[1][1:0], grantLog[2][1:0], grantLog[3][1:0]}, 8'b01_00_01_00);

    // out-of-range requests and saturation
    doReset();
    request(1, 2'd0, 32'd1024); tick();
    chk("err_first_count", oErrC, 8'd1);
    chk("err_first_addr", oErrA, 32'd1024);
    chk("err_no_busy", oBusy, 0);
    begin
      int base;
      base = acceptCnt;
      addrIn[31:0] = 32'd2000; cmdInValid[0] = 1'b1;
      for (int n = 0; n < 1000 && acceptCnt < base + 300; n++) tick();
      cmdInValid[0] = 1'b0;
    end
    tick();
    chk("err_sat_count", oErrC, 8'd255);
    chk("err_sat_addr", oErrA, 32'd1024);

    // reset while waiting on the depth-1 response
    doReset();
    clearLogs(); setScript(0, 1, 1, 0, 0, 0); holdIdx = 1;
    request(0, 2'd0, 32'd100);
    for (int n = 0; n < 50 && lkLog.size() < 2; n++) tick();
    tick();
    chk("wait_busy", oBusy, 1);
    Reset = 0; #1;
    chk("async_reset", {oBusy, oLkV, oCmdV, oInit, oReady}, '0);
    tick(); Reset = 1; holdIdx = -1; tick();
    clearLogs(); setScript(1, 1, 1, 0, 0, 0);
    request(0, 2'd0, 32'd100); waitIdle();
    chkLogs("after_reset", 1, '{32'd100, 32'd0, 32'd0}, 1, '{{2'd0, 32'd100}, 34'd0, 34'd0}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
